// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback request ports and register-file write bus.
interface regfile_wb_arbiter_if;
    logic        s0_valid;
    logic [4:0]  s0_addr;
    logic [31:0] s0_data;
    logic        s0_ready;
    logic        s1_valid;
    logic [4:0]  s1_addr;
    logic [31:0] s1_data;
    logic        s1_ready;
    logic        write_enable;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic        grant_id;
    logic [7:0]  drop_cnt;
    modport master (
        output s0_valid, s0_addr, s0_data, s1_valid, s1_addr, s1_data,
        input  s0_ready, s1_ready, write_enable, write_addr, write_data, grant_id, drop_cnt
    );
    modport slave (
        input  s0_valid, s0_addr, s0_data, s1_valid, s1_addr, s1_data,
        output s0_ready, s1_ready, write_enable, write_addr, write_data, grant_id, drop_cnt
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: two-port writeback arbiter, ALU priority with load-port anti-starvation.
module regfile_wb_arbiter #(
    parameter int STARVE_MAX = 3
) (
    input logic clk,
    input logic rst_n,
    regfile_wb_arbiter_if.slave wb
);
    logic [3:0]  starve_q, starve_d;
    logic        we_q, we_d;
    logic [4:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        gid_q, gid_d;
    logic [7:0]  drop_q, drop_d;
    logic        force1, t0, t1, xfer;
    logic [4:0]  sel_addr;
    logic [31:0] sel_data;

    always_comb begin
        force1    = wb.s1_valid && (starve_q == 4'(STARVE_MAX));
        wb.s0_ready = !force1;
        wb.s1_ready = force1 || !wb.s0_valid;
        t0        = wb.s0_valid && wb.s0_ready;
        t1        = wb.s1_valid && wb.s1_ready;
        xfer      = t0 || t1;
        sel_addr  = t1 ? wb.s1_addr : wb.s0_addr;
        sel_data  = t1 ? wb.s1_data : wb.s0_data;
        starve_d  = (t1 || !wb.s1_valid) ? 4'd0 :
                    (starve_q == 4'(STARVE_MAX)) ? starve_q : starve_q + 4'd1;
        we_d      = xfer && (sel_addr != 5'd31);
        addr_d    = xfer ? sel_addr : addr_q;
        data_d    = xfer ? sel_data : data_q;
        gid_d     = xfer ? t1 : gid_q;
        // Writes to r31 are swallowed; count them without wrapping.
        drop_d    = (xfer && sel_addr == 5'd31 && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            gid_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            starve_q <= starve_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            gid_q    <= gid_d;
            drop_q   <= drop_d;
        end
    end

    assign wb.write_enable = we_q;
    assign wb.write_addr   = addr_q;
    assign wb.write_data   = data_q;
    assign wb.grant_id     = gid_q;
    assign wb.drop_cnt     = drop_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed vector table plus hand sequences for same-address, drop saturation and reset.
module tb_regfile_wb_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [31:0] rf [32];

    regfile_wb_arbiter_if bus ();
    regfile_wb_arbiter #(.STARVE_MAX(3)) dut (.clk(clk), .rst_n(rst_n), .wb(bus));

    always #5 clk = ~clk;

    // Register file model commits on the falling edge after write_enable rises.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (bus.write_enable) begin
            rf[bus.write_addr] <= bus.write_data;
        end
    end

    typedef struct {
        logic        s0v;
        logic [4:0]  s0a;
        logic [31:0] s0d;
        logic        s1v;
        logic [4:0]  s1a;
        logic [31:0] s1d;
        logic        r0;
        logic        r1;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        gid;
        logic [7:0]  drop;
        logic [3:0]  stv;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s0v, input logic [4:0] s0a, input logic [31:0] s0d,
                         input logic s1v, input logic [4:0] s1a, input logic [31:0] s1d);
        bus.s0_valid = s0v; bus.s0_addr = s0a; bus.s0_data = s0d;
        bus.s1_valid = s1v; bus.s1_addr = s1a; bus.s1_data = s1d;
    endtask

    task automatic step(input int idx, input vec_t v);
        @(negedge clk);
        drive(v.s0v, v.s0a, v.s0d, v.s1v, v.s1a, v.s1d);
        #1;
        chk($sformatf("v%0d s0_ready", idx), 32'(bus.s0_ready), 32'(v.r0));
        chk($sformatf("v%0d s1_ready", idx), 32'(bus.s1_ready), 32'(v.r1));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d write_enable", idx), 32'(bus.write_enable), 32'(v.we));
        chk($sformatf("v%0d write_addr", idx), 32'(bus.write_addr), 32'(v.wa));
        chk($sformatf("v%0d write_data", idx), bus.write_data, v.wd);
        chk($sformatf("v%0d grant_id", idx), 32'(bus.grant_id), 32'(v.gid));
        chk($sformatf("v%0d drop_cnt", idx), 32'(bus.drop_cnt), 32'(v.drop));
        chk($sformatf("v%0d starve_cnt", idx), 32'(dut.starve_q), 32'(v.stv));
    endtask

    initial begin
        //           s0v s0a    s0d    s1v s1a    s1d          r0 r1 we wa     wd           g  drop stv
        vecs[0]  = '{0, 5'd0,  32'h0,  0, 5'd0,  32'h0,        1, 1, 0, 5'd0,  32'h0,       0, 0, 0};
        vecs[1]  = '{1, 5'd5,  32'hAA, 0, 5'd0,  32'h0,        1, 0, 1, 5'd5,  32'hAA,      0, 0, 0};
        vecs[2]  = '{0, 5'd0,  32'h0,  0, 5'd0,  32'h0,        1, 1, 0, 5'd5,  32'hAA,      0, 0, 0};
        vecs[3]  = '{0, 5'd0,  32'h0,  1, 5'd8,  32'h3,        1, 1, 1, 5'd8,  32'h3,       1, 0, 0};
        vecs[4]  = '{1, 5'd2,  32'h1,  1, 5'd7,  32'h2,        1, 0, 1, 5'd2,  32'h1,       0, 0, 1};
        vecs[5]  = '{1, 5'd2,  32'h1,  1, 5'd7,  32'h2,        1, 0, 1, 5'd2,  32'h1,       0, 0, 2};
        vecs[6]  = '{1, 5'd2,  32'h1,  1, 5'd7,  32'h2,        1, 0, 1, 5'd2,  32'h1,       0, 0, 3};
        vecs[7]  = '{1, 5'd2,  32'h1,  1, 5'd7,  32'h2,        0, 1, 1, 5'd7,  32'h2,       1, 0, 0};
        vecs[8]  = '{1, 5'd2,  32'h1,  1, 5'd7,  32'h2,        1, 0, 1, 5'd2,  32'h1,       0, 0, 1};
        vecs[9]  = '{0, 5'd0,  32'h0,  1, 5'd31, 32'hFFFFFFFF, 1, 1, 0, 5'd31, 32'hFFFFFFFF, 1, 1, 0};
        vecs[10] = '{0, 5'd0,  32'h0,  0, 5'd0,  32'h0,        1, 1, 0, 5'd31, 32'hFFFFFFFF, 1, 1, 0};
        vecs[11] = '{1, 5'd31, 32'h5,  0, 5'd0,  32'h0,        1, 0, 0, 5'd31, 32'h5,       0, 2, 0};

        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        #6;
        chk("reset write_enable", 32'(bus.write_enable), 32'h0);
        chk("reset write_addr", 32'(bus.write_addr), 32'h0);
        chk("reset write_data", bus.write_data, 32'h0);
        chk("reset grant_id", 32'(bus.grant_id), 32'h0);
        chk("reset drop_cnt", 32'(bus.drop_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) step(i, vecs[i]);
        chk("rf r5", rf[5], 32'hAA);
        chk("rf r8", rf[8], 32'h3);
        chk("rf r7", rf[7], 32'h2);
        chk("rf r2", rf[2], 32'h1);
        chk("rf r31", rf[31], 32'h0);

        // Same destination from both ports: ALU first, load second, load value lands last.
        @(negedge clk);
        drive(1, 5'd4, 32'h11, 1, 5'd4, 32'h22);
        @(negedge clk);
        drive(0, 5'd0, 32'h0, 1, 5'd4, 32'h22);
        #1;
        chk("same addr first commit", rf[4], 32'h11);
        @(negedge clk);
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        #1;
        chk("same addr final r4", rf[4], 32'h22);
        chk("same addr grant_id", 32'(bus.grant_id), 32'h1);

        // Drop counter saturation with 300 writes to r31.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            drive(0, 5'd0, 32'h0, 1, 5'd31, 32'hFFFFFFFF);
            #1;
            if (i == 0) chk("r31 s1_ready", 32'(bus.s1_ready), 32'h1);
            @(posedge clk);
            #1;
            if (i == 0) chk("r31 first drop_cnt", 32'(bus.drop_cnt), 32'h3);
            if (i == 0) chk("r31 write_enable", 32'(bus.write_enable), 32'h0);
        end
        chk("drop_cnt saturated", 32'(bus.drop_cnt), 32'hFF);

        // Reset during the cycle after a transfer.
        @(negedge clk);
        drive(1, 5'd9, 32'h55, 0, 5'd0, 32'h0);
        @(posedge clk);
        #1;
        chk("pre-reset write_enable", 32'(bus.write_enable), 32'h1);
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid reset write_enable", 32'(bus.write_enable), 32'h0);
        chk("mid reset write_addr", 32'(bus.write_addr), 32'h0);
        chk("mid reset write_data", bus.write_data, 32'h0);
        chk("mid reset grant_id", 32'(bus.grant_id), 32'h0);
        chk("mid reset drop_cnt", 32'(bus.drop_cnt), 32'h0);
        chk("mid reset starve_cnt", 32'(dut.starve_q), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post reset idle we %0d", i), 32'(bus.write_enable), 32'h0);
        end
        step(99, '{1, 5'd9, 32'h55, 0, 5'd0, 32'h0, 1, 0, 1, 5'd9, 32'h55, 0, 0, 0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL use one clock, `clk`, and one asynchronous, active-low reset, `rst_n`.
REQ-002 Parameter STARVE_MAX SHALL default to 3 and SHALL be the number of consecutive cycles port 1 may be refused before it is forced to win (legal range 1..15).
REQ-003 `clk` SHALL be an input, 1 bit wide, and SHALL be the rising-edge clock for all state.
REQ-004 `rst_n` SHALL be an input, 1 bit wide, and SHALL be the async active-low reset.
REQ-005 `s0_valid` SHALL be an input, 1 bit wide, and SHALL mean that the ALU writeback request is present.
REQ-006 `s0_addr` SHALL be an input, 5 bits wide, and SHALL be the ALU destination register.
REQ-007 `s0_data` SHALL be an input, 32 bits wide, and SHALL be the ALU result.
REQ-008 `s0_ready` SHALL be an output, 1 bit wide and combinational, and SHALL mean that port 0 is accepted this cycle.
REQ-009 `s1_valid` SHALL be an input, 1 bit wide, and SHALL mean that the load-unit writeback request is present.
REQ-010 `s1_addr` SHALL be an input, 5 bits wide, and SHALL be the load destination register.
REQ-011 `s1_data` SHALL be an input, 32 bits wide, and SHALL be the load data.
REQ-012 `s1_ready` SHALL be an output, 1 bit wide and combinational, and SHALL mean that port 1 is accepted this cycle.
REQ-013 `write_enable` SHALL be an output, 1 bit wide and registered, and SHALL drive the register file write enable.
REQ-014 `write_addr` SHALL be an output, 5 bits wide and registered, and SHALL drive the register file write address.
REQ-015 `write_data` SHALL be an output, 32 bits wide and registered, and SHALL drive the register file write data.
REQ-016 `grant_id` SHALL be an output, 1 bit wide and registered, and SHALL identify the port that won the last accepted transfer.
REQ-017 `drop_cnt` SHALL be an output, 8 bits wide and registered, and SHALL be a saturating count of writes that targeted register 31.

Function
REQ-018 A transfer on port k SHALL occur when sk_valid and sk_ready are both 1 at a rising edge of `clk`; at most one transfer SHALL occur per cycle.
REQ-019 The signal force1 SHALL be defined as s1_valid && (starve_cnt == STARVE_MAX).
REQ-020 s0_ready SHALL equal !force1.
REQ-021 s1_ready SHALL equal force1 || !s0_valid.
REQ-022 The 4-bit starve_cnt SHALL clear on a port-1 transfer or when s1_valid is 0.
REQ-023 Otherwise, starve_cnt SHALL increment, saturating at STARVE_MAX.
REQ-024 On a transfer, the next edge SHALL load write_addr and write_data from the winning port and set grant_id to k.
REQ-025 On that same edge, write_enable SHALL be set to (addr != 5'd31).
REQ-026 In a cycle with no transfer, write_enable SHALL be 0 at the next edge, and write_addr, write_data and grant_id SHALL hold their values.
REQ-027 Latency from a transfer edge to write_enable=1 SHALL be one cycle, and the register file SHALL commit on the following falling edge of `clk`.
REQ-028 A transfer with addr = 31 SHALL be accepted, SHALL NOT assert write_enable, and SHALL increment drop_cnt, which saturates at 255.
REQ-029 When both ports request the same address, both SHALL be written in grant order, and the later grant SHALL be the final register value.
REQ-030 A requester SHALL hold valid, addr and data stable until its transfer, and the block SHALL NOT register inputs that were not granted.
REQ-031 When s1_valid is 1, s1 SHALL be granted within STARVE_MAX+1 cycles regardless of s0 activity.

Reset
REQ-032 While rst_n=0, the block SHALL force write_enable=0, write_addr=0, write_data=0, grant_id=0, drop_cnt=0 and starve_cnt=0, taking effect immediately and without waiting for a clock edge.
REQ-033 A reset asserted mid-transfer SHALL discard that transfer, so that no write_enable pulse appears after reset.
REQ-034 The block SHALL resume arbitration at the first rising edge after rst_n rises.

Verification
REQ-035 Port 0 only: s0 presents (addr 5, data 32'h0000_00AA) for 1 cycle -> write_enable=1 with addr 5 / data AA one cycle later, grant_id=0, and register file r5=AA after the following falling edge.
REQ-036 Both ports valid continuously, s0 = (2, 1), s1 = (7, 2), STARVE_MAX=3 -> s0 wins 3 cycles, s1 wins cycle 4, and the pattern repeats every 4 cycles.
REQ-037 Same address: s0 = (4, 11) and s1 = (4, 22) both valid with s0 then idle -> writes 11 then 22, and r4=22 at the end.
REQ-038 Addr 31: s1 = (31, FFFF_FFFF) -> s1_ready=1, write_enable stays 0, and drop_cnt goes 0 to 1; 300 such writes -> drop_cnt=255.
REQ-039 Reset mid-stream: rst_n=0 asserted during the cycle after a transfer -> write_enable=0 immediately, all outputs 0, and no write occurs after rst_n rises until a new transfer.
REQ-040 Port 1 only, idle port 0: s1 = (8, 3) -> s1_ready=1 in the same cycle, write_enable next cycle, grant_id=1, and starve_cnt stays 0.
